// File: rtl/fusion_pkg.sv
// Shared types for the Bit Fusion column: FSM states, the latched precision
// config and the legal-width check used when a tile is started.
package fusion_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] in_width;
    logic [3:0] weight_width;
    logic       s_in;
    logic       s_weight;
  } fusion_cfg_t;

  function automatic logic width_legal(input logic [3:0] w);
    return (w == 4'd1) || (w == 4'd2) || (w == 4'd4) || (w == 4'd8);
  endfunction

endpackage

// File: rtl/fusion_skew.sv
// Fixed-depth operand delay line; unit k of the column sits behind one of
// depth k so its operands line up with the psum arriving from unit k-1.
module fusion_skew #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  // NOTE: the delay line has no reset; stale words are harmless because the
  // column's valid pipe decides what gets accumulated, and resetting a
  // storage array only costs routing.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let every stage sample the old value of
    // its predecessor, so the loop order cannot collapse the delay line.
    pipe_q[0] <= d;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q = pipe_q[DEPTH-1];

endmodule

// File: rtl/fusion_unit.sv
// One Bit Fusion unit: splits its byte operands into up to four lanes by
// precision, multiplies per lane and adds onto psum_in; psum_fwd is registered.
module fusion_unit
  import fusion_pkg::*;
#(
  parameter int COL_WIDTH = 9
) (
  input  logic                       clk,
  input  fusion_cfg_t                cfg,
  input  logic [7:0]                 in,
  input  logic [31:0]                weight,
  input  logic [LANES*COL_WIDTH-1:0] psum_in,
  output logic [LANES*COL_WIDTH-1:0] psum_fwd
);

  // Element idx of the given precision from a byte, extended to 9 bits.
  function automatic logic signed [8:0] elem(input logic [7:0] src,
                                             input logic [3:0] width,
                                             input logic [1:0] idx,
                                             input logic       is_signed);
    logic [7:0] sh;
    logic [8:0] ext;
    sh = src >> (int'(idx) * int'(width));
    case (width)
      4'd1:    ext = {{8{is_signed & sh[0]}}, sh[0]};
      4'd2:    ext = {{7{is_signed & sh[1]}}, sh[1:0]};
      4'd4:    ext = {{5{is_signed & sh[3]}}, sh[3:0]};
      default: ext = {is_signed & sh[7], sh};
    endcase
    return $signed(ext);
  endfunction

  logic [2:0]                 lanes_used;
  logic signed [17:0]         prod [LANES];
  logic [LANES*COL_WIDTH-1:0] psum_d;

  // The wider of the two precisions decides how many lanes are active.
  always_comb begin
    if (cfg.in_width == 4'd8 || cfg.weight_width == 4'd8) begin
      lanes_used = 3'd1;
    end else if (cfg.in_width == 4'd4 || cfg.weight_width == 4'd4) begin
      lanes_used = 3'd2;
    end else begin
      lanes_used = 3'd4;
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod[i] = elem(in, cfg.in_width, 2'(i), cfg.s_in)
              * elem(weight[i*8 +: 8], cfg.weight_width, 2'd0, cfg.s_weight);
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns psum_d and no latch is inferred.
    psum_d = psum_in;
    for (int i = 0; i < LANES; i++) begin
      if (3'(i) < lanes_used) begin
        psum_d[i*COL_WIDTH +: COL_WIDTH] = psum_in[i*COL_WIDTH +: COL_WIDTH]
                                         + COL_WIDTH'(prod[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    psum_fwd <= psum_d;
  end

endmodule

// File: rtl/fusion_column.sv
// Systolic column of NUM_UNITS fusion units with skewed operand delivery;
// accumulates valid column outputs over a tile and returns one 4-lane psum.
module fusion_column
  import fusion_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int COL_WIDTH = 9,
  parameter int ACC_WIDTH = 24,
  parameter int ACC_LEN_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [3:0]                 in_width,
  input  logic [3:0]                 weight_width,
  input  logic                       s_in,
  input  logic                       s_weight,
  input  logic [ACC_LEN_W-1:0]       acc_len,
  output logic                       cfg_err,
  output logic                       busy,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_UNITS*8-1:0]     in,
  input  logic [NUM_UNITS*32-1:0]    weight,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*ACC_WIDTH-1:0] out_psum
);

  localparam int PSUM_W = LANES * COL_WIDTH;

  state_e                          state_q, state_d;
  fusion_cfg_t                     cfg_q, cfg_d;
  logic [ACC_LEN_W-1:0]            last_q, last_d;
  logic [ACC_LEN_W-1:0]            cnt_q, cnt_d;
  logic [LANES*ACC_WIDTH-1:0]      acc_q, acc_d, acc_sum;
  logic [NUM_UNITS:0]              vld_q, vld_d;
  logic                            cfg_err_q, cfg_err_d;
  logic                            accept;
  logic                            cfg_ok;
  logic [NUM_UNITS*8-1:0]          in_q;
  logic [NUM_UNITS*32-1:0]         weight_q;
  logic [NUM_UNITS:0][PSUM_W-1:0]  chain;
  logic signed [COL_WIDTH-1:0]     lane_s;
  logic [ACC_WIDTH-1:0]            lane_ext;

  assign cfg_ok    = width_legal(in_width) && width_legal(weight_width);
  assign busy      = (state_q != ST_IDLE);
  assign in_ready  = (state_q == ST_RUN);
  assign out_valid = (state_q == ST_HOLD);
  assign cfg_err   = cfg_err_q;
  assign out_psum  = acc_q;
  assign accept    = in_valid && in_ready;

  // Bit 0 marks the input stage, bit k+1 the output of unit k.
  assign vld_d = {vld_q[NUM_UNITS-1:0], accept};

  // Column output lanes are extended by the tile's signedness before adding.
  always_comb begin
    acc_sum  = acc_q;
    lane_s   = '0;
    lane_ext = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_s = chain[NUM_UNITS][i*COL_WIDTH +: COL_WIDTH];
      if (cfg_q.s_in || cfg_q.s_weight) begin
        lane_ext = ACC_WIDTH'(lane_s);
      end else begin
        lane_ext = ACC_WIDTH'($unsigned(lane_s));
      end
      acc_sum[i*ACC_WIDTH +: ACC_WIDTH] = acc_q[i*ACC_WIDTH +: ACC_WIDTH] + lane_ext;
    end
  end

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    cfg_err_d = 1'b0;
    acc_d     = vld_q[NUM_UNITS] ? acc_sum : acc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            cfg_d   = '{in_width: in_width, weight_width: weight_width,
                        s_in: s_in, s_weight: s_weight};
            last_d  = (acc_len == '0) ? '0 : acc_len - 1'b1;
            cnt_d   = '0;
            acc_d   = '0;
            state_d = ST_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (cnt_q == last_q) begin
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // An empty pipe means the last column output was added last cycle.
        if (vld_q == '0) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cfg_q     <= '0;
      last_q    <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      vld_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      vld_q     <= vld_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      in_q     <= in;
      weight_q <= weight;
    end
  end

  assign chain[0] = '0;

  for (genvar k = 0; k < NUM_UNITS; k++) begin : g_unit
    logic [39:0] ops;
    if (k == 0) begin : g_direct
      assign ops = {in_q[0 +: 8], weight_q[0 +: 32]};
    end else begin : g_skew
      fusion_skew #(
        .WIDTH(40),
        .DEPTH(k)
      ) u_skew (
        .clk(clk),
        .d  ({in_q[k*8 +: 8], weight_q[k*32 +: 32]}),
        .q  (ops)
      );
    end

    fusion_unit #(
      .COL_WIDTH(COL_WIDTH)
    ) u_unit (
      .clk     (clk),
      .cfg     (cfg_q),
      .in      (ops[39:32]),
      .weight  (ops[31:0]),
      .psum_in (chain[k]),
      .psum_fwd(chain[k+1])
    );
  end

endmodule

// File: tb/tb_fusion_column.sv
// Self-checking bench for fusion_column: directed tiles from the test plan
// plus randomized 8b x 8b tiles checked against an arithmetic model.
module tb_fusion_column;

  localparam int N  = 2;
  localparam int CW = 9;
  localparam int AW = 16;
  localparam int LW = 8;
  localparam int L  = 1 + N;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [3:0]      in_width;
  logic [3:0]      weight_width;
  logic            s_in;
  logic            s_weight;
  logic [LW-1:0]   acc_len;
  logic            cfg_err;
  logic            busy;
  logic            in_valid;
  logic            in_ready;
  logic [N*8-1:0]  in_bus;
  logic [N*32-1:0] w_bus;
  logic            out_valid;
  logic            out_ready;
  logic [4*AW-1:0] out_psum;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [N*8-1:0]  q_in [$];
  logic [N*32-1:0] q_w  [$];

  fusion_column #(
    .NUM_UNITS(N),
    .COL_WIDTH(CW),
    .ACC_WIDTH(AW),
    .ACC_LEN_W(LW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_width    (in_width),
    .weight_width(weight_width),
    .s_in        (s_in),
    .s_weight    (s_weight),
    .acc_len     (acc_len),
    .cfg_err     (cfg_err),
    .busy        (busy),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in          (in_bus),
    .weight      (w_bus),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_psum    (out_psum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Each beat contributes sum_k in_k*w_k, seen through a 9-bit lane and
  // extended by signedness; the accumulator wraps at 2^AW.
  function automatic logic [4*AW-1:0] model(input bit si, input bit sw,
                                            input int first, input int n);
    longint acc;
    longint s;
    longint a;
    longint b;
    logic [N*8-1:0]  iv;
    logic [N*32-1:0] wv;
    logic [7:0]      ib;
    logic [7:0]      wb;
    logic [4*AW-1:0] r;
    acc = 0;
    for (int j = first; j < first + n; j++) begin
      iv = q_in[j];
      wv = q_w[j];
      s  = 0;
      for (int k = 0; k < N; k++) begin
        ib = iv[k*8 +: 8];
        wb = wv[k*32 +: 8];
        a  = si ? longint'($signed(ib)) : longint'(ib);
        b  = sw ? longint'($signed(wb)) : longint'(wb);
        s  = s + a * b;
      end
      s = s & 511;
      if ((si || sw) && s >= 256) s = s - 512;
      acc = (acc + s) & ((longint'(1) << AW) - 1);
    end
    r = '0;
    r[AW-1:0] = acc[AW-1:0];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(input logic [3:0] iw, input logic [3:0] ww,
                            input bit si, input bit sw, input int len,
                            output int s0);
    in_width     = iw;
    weight_width = ww;
    s_in         = si;
    s_weight     = sw;
    acc_len      = LW'(len);
    start        = 1'b1;
    step();
    start = 1'b0;
    s0    = cyc;
  endtask

  // Offers beats q[first .. first+n-1]; alt forces a bubble on every other cycle.
  task automatic feed(input int first, input int n, input int bubble_pct,
                      input bit alt, output int last_acc, output bit ok);
    int idx;
    int guard;
    bit take;
    idx      = first;
    guard    = 0;
    last_acc = -1;
    while (idx < first + n && guard < 5000) begin
      if (alt ? (guard % 2 == 0) : ($urandom_range(99) < bubble_pct)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_bus   = q_in[idx];
        w_bus    = q_w[idx];
      end
      take = in_valid && in_ready;
      step();
      if (take) begin
        last_acc = cyc;
        idx++;
      end
      guard++;
    end
    in_valid = 1'b0;
    ok = (idx == first + n);
  endtask

  task automatic wait_out(output int seen, output bit ok);
    int g;
    g = 0;
    while (!out_valid && g < 400) begin
      step();
      g++;
    end
    ok   = out_valid;
    seen = cyc;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({busy, in_ready, out_valid, cfg_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: busy/in_ready/out_valid/cfg_err got %b want 0000",
               {busy, in_ready, out_valid, cfg_err});
    end
    checks++;
    if (out_psum !== '0) begin
      errors++;
      $display("FAIL reset_psum: got %h want 0", out_psum);
    end
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy got %b want 0", busy);
    end
  endtask

  task automatic test_8b_sum();
    int s0, last, seen;
    bit ok1, ok2;
    q_in.delete();
    q_w.delete();
    repeat (3) begin
      q_in.push_back({8'd3, 8'd2});
      q_w.push_back({32'd7, 32'd5});
    end
    start_tile(4'd8, 4'd8, 1'b0, 1'b0, 3, s0);
    feed(0, 3, 0, 1'b0, last, ok1);
    wait_out(seen, ok2);
    checks++;
    if (!(ok1 && ok2)) begin
      errors++;
      $display("FAIL sum8_timeout: feed_ok=%0b out_valid=%0b want 1/1", ok1, ok2);
    end
    checks++;
    if (seen - last !== L + 1) begin
      errors++;
      $display("FAIL sum8_latency: got %0d edges want %0d", seen - last, L + 1);
    end
    checks++;
    if (out_psum[AW-1:0] !== 16'd93) begin
      errors++;
      $display("FAIL sum8_lane0: got %0d want 93", out_psum[AW-1:0]);
    end
    checks++;
    if (out_psum[4*AW-1:AW] !== '0) begin
      errors++;
      $display("FAIL sum8_lanes123: got %h want 0", out_psum[4*AW-1:AW]);
    end
    take_result();
  endtask

  task automatic test_bubbles();
    int s0, last, seen;
    bit ok1, ok2;
    start_tile(4'd8, 4'd8, 1'b0, 1'b0, 3, s0);
    feed(0, 3, 0, 1'b1, last, ok1);
    wait_out(seen, ok2);
    checks++;
    if (!(ok1 && ok2)) begin
      errors++;
      $display("FAIL bubble_timeout: feed_ok=%0b out_valid=%0b want 1/1", ok1, ok2);
    end
    checks++;
    if (seen - s0 !== 3 + 3 + L + 1) begin
      errors++;
      $display("FAIL bubble_latency: got %0d edges after start want %0d",
               seen - s0, 3 + 3 + L + 1);
    end
    checks++;
    if (out_psum !== {{(3*AW){1'b0}}, 16'd93}) begin
      errors++;
      $display("FAIL bubble_result: got %h want lane0=93", out_psum);
    end
    take_result();
  endtask

  task automatic test_signed_wrap();
    int s0, last, seen;
    bit ok1, ok2;
    q_in.delete();
    q_w.delete();
    repeat (255) begin
      q_in.push_back({8'h00, 8'hFF});
      q_w.push_back({32'h0, 32'h80});
    end
    start_tile(4'd8, 4'd8, 1'b1, 1'b1, 0, s0);
    feed(0, 1, 0, 1'b0, last, ok1);
    wait_out(seen, ok2);
    checks++;
    if (!(ok1 && ok2) || out_psum !== {{(3*AW){1'b0}}, 16'd128}) begin
      errors++;
      $display("FAIL signed_len0: got %h ok=%0b want lane0=128", out_psum, ok1 && ok2);
    end
    take_result();
    start_tile(4'd8, 4'd8, 1'b1, 1'b1, 255, s0);
    feed(0, 255, 0, 1'b0, last, ok1);
    wait_out(seen, ok2);
    checks++;
    if (!(ok1 && ok2) || out_psum !== {{(3*AW){1'b0}}, 16'd32640}) begin
      errors++;
      $display("FAIL signed_len255: got %h ok=%0b want lane0=32640", out_psum, ok1 && ok2);
    end
    take_result();
  endtask

  task automatic test_illegal_cfg();
    int s0;
    start_tile(4'd3, 4'd8, 1'b0, 1'b0, 2, s0);
    checks++;
    if ({cfg_err, busy, in_ready} !== 3'b100) begin
      errors++;
      $display("FAIL illegal_pulse: cfg_err/busy/in_ready got %b want 100",
               {cfg_err, busy, in_ready});
    end
    step();
    checks++;
    if ({cfg_err, busy, in_ready} !== 3'b000) begin
      errors++;
      $display("FAIL illegal_after: cfg_err/busy/in_ready got %b want 000",
               {cfg_err, busy, in_ready});
    end
    start_tile(4'd8, 4'd0, 1'b0, 1'b0, 2, s0);
    checks++;
    if ({cfg_err, busy} !== 2'b10) begin
      errors++;
      $display("FAIL illegal_weight: cfg_err/busy got %b want 10", {cfg_err, busy});
    end
    step();
  endtask

  task automatic test_backpressure();
    int s0, last, seen;
    bit ok1, ok2;
    logic [4*AW-1:0] exp;
    q_in.delete();
    q_w.delete();
    repeat (2) begin
      q_in.push_back(N*8'($urandom));
      q_w.push_back({$urandom, $urandom});
    end
    exp = model(1'b0, 1'b0, 0, 2);
    start_tile(4'd8, 4'd8, 1'b0, 1'b0, 2, s0);
    feed(0, 2, 0, 1'b0, last, ok1);
    wait_out(seen, ok2);
    checks++;
    if (!(ok1 && ok2)) begin
      errors++;
      $display("FAIL bp_timeout: feed_ok=%0b out_valid=%0b want 1/1", ok1, ok2);
    end
    for (int c = 0; c < 10; c++) begin
      out_ready    = 1'b0;
      start        = 1'b1;
      acc_len      = LW'(5);
      step();
      checks++;
      if (out_psum !== exp || {out_valid, in_ready, busy} !== 3'b101) begin
        errors++;
        $display("FAIL bp_hold[%0d]: psum=%h valid/ready/busy=%b want psum=%h 101",
                 c, out_psum, {out_valid, in_ready, busy}, exp);
      end
    end
    start = 1'b0;
    take_result();
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL bp_release: out_valid/busy got %b want 00", {out_valid, busy});
    end
  endtask

  task automatic test_reset_mid_tile();
    int s0, last, seen;
    bit ok1, ok2;
    logic [4*AW-1:0] exp;
    q_in.delete();
    q_w.delete();
    repeat (5) begin
      q_in.push_back(N*8'($urandom));
      q_w.push_back({$urandom, $urandom});
    end
    exp = model(1'b0, 1'b0, 4, 1);
    start_tile(4'd8, 4'd8, 1'b0, 1'b0, 4, s0);
    feed(0, 2, 0, 1'b0, last, ok1);
    rst = 1'b1;
    step();
    checks++;
    if ({busy, in_ready, out_valid, cfg_err} !== 4'b0000 || out_psum !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: ctrl=%b psum=%h want 0000 and 0",
               {busy, in_ready, out_valid, cfg_err}, out_psum);
    end
    rst = 1'b0;
    step();
    start_tile(4'd8, 4'd8, 1'b0, 1'b0, 1, s0);
    feed(4, 1, 0, 1'b0, last, ok1);
    wait_out(seen, ok2);
    checks++;
    if (!(ok1 && ok2) || out_psum !== exp) begin
      errors++;
      $display("FAIL midrst_newtile: got %h ok=%0b want %h", out_psum, ok1 && ok2, exp);
    end
    take_result();
  endtask

  task automatic test_random();
    int s0, last, seen, len, n;
    bit ok1, ok2, si, sw;
    logic [4*AW-1:0] exp;
    for (int t = 0; t < 8; t++) begin
      si  = 1'($urandom);
      sw  = 1'($urandom);
      len = $urandom_range(0, 6);
      n   = (len == 0) ? 1 : len;
      q_in.delete();
      q_w.delete();
      repeat (n) begin
        q_in.push_back(N*8'($urandom));
        q_w.push_back({$urandom, $urandom});
      end
      exp = model(si, sw, 0, n);
      start_tile(4'd8, 4'd8, si, sw, len, s0);
      feed(0, n, 30, 1'b0, last, ok1);
      wait_out(seen, ok2);
      checks++;
      if (!(ok1 && ok2) || seen - last !== L + 1) begin
        errors++;
        $display("FAIL rand_latency[%0d]: ok=%0b got %0d edges want %0d",
                 t, ok1 && ok2, seen - last, L + 1);
      end
      checks++;
      if (out_psum !== exp) begin
        errors++;
        $display("FAIL rand_result[%0d]: si=%0b sw=%0b len=%0d got %h want %h",
                 t, si, sw, len, out_psum, exp);
      end
      repeat ($urandom_range(0, 3)) step();
      take_result();
    end
  endtask

  task automatic test_back_to_back();
    int s0, last, seen;
    bit ok1, ok2;
    logic [4*AW-1:0] exp_a, exp_b;
    q_in.delete();
    q_w.delete();
    repeat (4) begin
      q_in.push_back(N*8'($urandom));
      q_w.push_back({$urandom, $urandom});
    end
    exp_a = model(1'b1, 1'b0, 0, 2);
    exp_b = model(1'b0, 1'b1, 2, 2);
    start_tile(4'd8, 4'd8, 1'b1, 1'b0, 2, s0);
    feed(0, 2, 0, 1'b0, last, ok1);
    wait_out(seen, ok2);
    checks++;
    if (!(ok1 && ok2) || out_psum !== exp_a) begin
      errors++;
      $display("FAIL b2b_first: got %h ok=%0b want %h", out_psum, ok1 && ok2, exp_a);
    end
    take_result();
    checks++;
    if ({busy, in_ready} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_idle_bubble: busy/in_ready got %b want 00", {busy, in_ready});
    end
    start_tile(4'd8, 4'd8, 1'b0, 1'b1, 2, s0);
    feed(2, 2, 0, 1'b0, last, ok1);
    wait_out(seen, ok2);
    checks++;
    if (!(ok1 && ok2) || out_psum !== exp_b) begin
      errors++;
      $display("FAIL b2b_second: got %h ok=%0b want %h", out_psum, ok1 && ok2, exp_b);
    end
    take_result();
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    in_width     = 4'd8;
    weight_width = 4'd8;
    s_in         = 1'b0;
    s_weight     = 1'b0;
    acc_len      = '0;
    in_bus       = '0;
    w_bus        = '0;
    test_reset();
    test_8b_sum();
    test_bubbles();
    test_signed_wrap();
    test_illegal_cfg();
    test_backpressure();
    test_reset_mid_tile();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
